// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit owning the HI/LO register pair.
// A start is taken only in IDLE. Multiplies finish after MUL_STAGES cycles.
// Divides use XLEN restoring steps plus one sign-fixup cycle.
// flush aborts whatever is in flight without touching HI/LO.
module mdu_hilo #(
   parameter int XLEN       = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] opb,
   input  logic            flush,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            busy,
   output logic            done
);

   localparam logic [2:0] opMult  = 3'd1;
   localparam logic [2:0] opMultu = 3'd2;
   localparam logic [2:0] opDiv   = 3'd3;
   localparam logic [2:0] opDivu  = 3'd4;
   localparam logic [2:0] opMthi  = 3'd5;
   localparam logic [2:0] opMtlo  = 3'd6;

   // One counter serves both the multiply latency and the divide iterations.
   localparam int CMAX  = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
   localparam int CNT_W = $clog2(CMAX + 1);
   localparam logic [CNT_W-1:0] mulLast = (MUL_STAGES > 1) ? CNT_W'(MUL_STAGES - 2) : '0;
   localparam logic [CNT_W-1:0] divLast = CNT_W'(XLEN - 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} stateT;

   stateT state, nextState;

   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] prodR;
   logic [XLEN-1:0]   remR, quoR, dvsR;
   logic              negQ, negR;

   logic loadMul, writeMul, loadDiv, stepDiv, writeDiv, writeZero, writeHi, writeLo;

   // Operands sign- or zero-extended so one truncated multiply serves both flavours.
   logic              sgnOp;
   logic [2*XLEN-1:0] aExt, bExt, mulNow;
   logic              aNeg, bNeg;
   logic [XLEN:0]     remShift;
   logic [XLEN-1:0]   remSub;

   assign sgnOp    = (op == opMult) || (op == opDiv);
   assign aExt     = {{XLEN{sgnOp & opa[XLEN-1]}}, opa};
   assign bExt     = {{XLEN{sgnOp & opb[XLEN-1]}}, opb};
   assign mulNow   = aExt * bExt;
   assign aNeg     = sgnOp & opa[XLEN-1];
   assign bNeg     = sgnOp & opb[XLEN-1];
   assign remShift = {remR, quoR[XLEN-1]};
   assign remSub   = remShift[XLEN-1:0] - dvsR;
   assign busy     = (state != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   // Next-state and datapath controls; flush kills every action this cycle.
   always_comb begin
      nextState = state;
      loadMul   = 1'b0;
      writeMul  = 1'b0;
      loadDiv   = 1'b0;
      stepDiv   = 1'b0;
      writeDiv  = 1'b0;
      writeZero = 1'b0;
      writeHi   = 1'b0;
      writeLo   = 1'b0;
      if (flush) begin
         nextState = IDLE;
      end else begin
         case (state)
            IDLE: if (start) begin
               case (op)
                  opMult, opMultu: begin
                     loadMul = 1'b1;
                     if (MUL_STAGES > 1) nextState = MUL;
                  end
                  opDiv, opDivu: begin
                     if (opb == '0) writeZero = 1'b1;
                     else begin
                        loadDiv   = 1'b1;
                        nextState = DIV;
                     end
                  end
                  opMthi:  writeHi = 1'b1;
                  opMtlo:  writeLo = 1'b1;
                  default: ;
               endcase
            end
            MUL: if (cnt == mulLast) begin
               writeMul  = 1'b1;
               nextState = IDLE;
            end
            DIV: begin
               stepDiv = 1'b1;
               if (cnt == divLast) nextState = FIX;
            end
            FIX: begin
               writeDiv  = 1'b1;
               nextState = IDLE;
            end
            default: nextState = IDLE;
         endcase
      end
   end

   // Datapath, HI/LO and the done pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
         cnt   <= '0;
         prodR <= '0;
         remR  <= '0;
         quoR  <= '0;
         dvsR  <= '0;
         negQ  <= 1'b0;
         negR  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (loadMul || loadDiv) cnt <= '0;
         else if (busy)          cnt <= cnt + CNT_W'(1);

         if (loadMul) begin
            // A single-stage multiplier commits straight from the issue cycle.
            if (MUL_STAGES == 1) begin
               {hi, lo} <= mulNow;
               done     <= 1'b1;
            end else begin
               prodR <= mulNow;
            end
         end
         if (writeMul) begin
            {hi, lo} <= prodR;
            done     <= 1'b1;
         end

         if (writeZero) begin
            hi   <= opa;
            lo   <= '1;
            done <= 1'b1;
         end
         if (loadDiv) begin
            remR <= '0;
            quoR <= aNeg ? -opa : opa;
            dvsR <= bNeg ? -opb : opb;
            negQ <= aNeg ^ bNeg;
            negR <= aNeg;
         end
         // Restoring step: dividend bits shift in MSB first; quotient bits enter at the bottom.
         if (stepDiv) begin
            if (remShift >= {1'b0, dvsR}) begin
               remR <= remSub;
               quoR <= {quoR[XLEN-2:0], 1'b1};
            end else begin
               remR <= remShift[XLEN-1:0];
               quoR <= {quoR[XLEN-2:0], 1'b0};
            end
         end
         // MIN_INT / -1 falls out naturally: magnitude 2^(XLEN-1), no negation.
         if (writeDiv) begin
            lo   <= negQ ? -quoR : quoR;
            hi   <= negR ? -remR : remR;
            done <= 1'b1;
         end

         if (writeHi) hi <= opa;
         if (writeLo) lo <= opa;
      end
   end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: expectations queued at issue, popped by a done monitor.
module tb_mdu_hilo;
   localparam int MS = 2;

   logic        clk, rst, start, flush;
   logic [2:0]  op;
   logic [31:0] opa, opb, hi, lo;
   logic        busy, done;

   mdu_hilo #(.XLEN(32), .MUL_STAGES(MS)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
      .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   typedef struct {
      logic [31:0] eHi;
      logic [31:0] eLo;
      int          eCyc;
      string       name;
   } expT;

   expT         expQ[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [31:0] expHi = '0;
   logic [31:0] expLo = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index, used to check when each done appears.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Reference model: {hi,lo} from plain arithmetic.
   function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint p;
      int sa, sb;
      logic [63:0] r;
      sa = a;
      sb = b;
      r  = '0;
      case (o)
         3'd1: begin p = longint'(sa) * longint'(sb); r = p; end
         3'd2: r = {32'd0, a} * {32'd0, b};
         3'd3: begin
            if (b == 0) r = {a, 32'hFFFFFFFF};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
            else r = {32'(sa % sb), 32'(sa / sb)};
         end
         3'd4: begin
            if (b == 0) r = {a, 32'hFFFFFFFF};
            else r = {a % b, a / b};
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Monitor: every done must match the oldest queued expectation, value and cycle.
   always @(negedge clk) begin
      if (rst && done) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 required no pending op (cycle %0d)", cyc);
         end else begin
            expT e;
            e = expQ.pop_front();
            chk({e.name, "_hi"}, hi, e.eHi);
            chk({e.name, "_lo"}, lo, e.eLo);
            chk({e.name, "_cyc"}, cyc, e.eCyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op at the current cycle, check busy length and final HI/LO.
   task automatic doOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string nm);
      logic [63:0] r;
      int n, expBusy, lat;
      bit hasDone;
      r = {expHi, expLo};
      hasDone = 0;
      expBusy = 0;
      lat = 0;
      case (o)
         3'd1, 3'd2: begin r = refModel(o, a, b); hasDone = 1; expBusy = MS - 1; lat = MS; end
         3'd3, 3'd4: begin
            r = refModel(o, a, b);
            hasDone = 1;
            if (b == 0) begin expBusy = 0; lat = 1; end
            else begin expBusy = 33; lat = 34; end
         end
         3'd5: r[63:32] = a;
         3'd6: r[31:0] = a;
         default: ;
      endcase
      if (hasDone) expQ.push_back('{r[63:32], r[31:0], cyc + lat, nm});
      start = 1'b1; op = o; opa = a; opb = b;
      tick();
      start = 1'b0; op = 3'd0;
      n = 0;
      while (busy && n < 100) begin n++; tick(); end
      chk({nm, "_busylen"}, n, expBusy);
      tick();
      expHi = r[63:32];
      expLo = r[31:0];
      chk({nm, "_hiend"}, hi, expHi);
      chk({nm, "_loend"}, lo, expLo);
   endtask

   initial begin
      int n;
      logic [2:0]  o;
      logic [31:0] a, b;
      rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; opa = '0; opb = '0;
      repeat (2) tick();
      // Reset state.
      rst = 1'b1;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_done", done, 32'd0);
      doOp(3'd7, 32'hDEAD, 32'hBEEF, "reserved");

      // Multiplies.
      doOp(3'd1, 32'hFFFFFFFE, 32'd3, "mult");
      doOp(3'd2, 32'hFFFFFFFE, 32'd3, "multu");

      // Divides and corners.
      doOp(3'd3, 32'hFFFFFFF9, 32'd2, "div_m7_2");
      doOp(3'd4, 32'd100, 32'd7, "divu_100_7");
      doOp(3'd4, 32'd100, 32'd0, "divu_by0");
      doOp(3'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");

      // Flush a divide at cycle 10.
      doOp(3'd5, 32'h1234, 32'd0, "mthi");
      start = 1'b1; op = 3'd3; opa = 32'd50; opb = 32'd5;
      tick();
      start = 1'b0; op = 3'd0;
      repeat (9) tick();
      chk("flush_busy_before", busy, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", busy, 32'd0);
      chk("flush_hi", hi, 32'h1234);
      chk("flush_lo", lo, expLo);
      doOp(3'd2, 32'd4, 32'd5, "multu_after_flush");

      // start while busy is ignored.
      begin
         logic [63:0] r;
         r = refModel(3'd3, 32'd1000, 32'hFFFFFFFD);
         expQ.push_back('{r[63:32], r[31:0], cyc + 34, "contend"});
         start = 1'b1; op = 3'd3; opa = 32'd1000; opb = 32'hFFFFFFFD;
         tick();
         start = 1'b0; op = 3'd0;
         repeat (2) tick();
         start = 1'b1; op = 3'd4; opa = 32'd77; opb = 32'd5;
         tick();
         start = 1'b0; op = 3'd0;
         n = 3;
         while (busy && n < 100) begin n++; tick(); end
         chk("contend_busylen", n, 33);
         tick();
         expHi = r[63:32];
         expLo = r[31:0];
         chk("contend_hi", hi, expHi);
         chk("contend_lo", lo, expLo);
      end

      // Reset in the middle of a divide.
      start = 1'b1; op = 3'd3; opa = 32'd999; opb = 32'd4;
      tick();
      start = 1'b0; op = 3'd0;
      repeat (4) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      expHi = '0;
      expLo = '0;
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      chk("midrst_busy", busy, 32'd0);
      chk("midrst_done", done, 32'd0);

      // start together with flush is dropped.
      doOp(3'd6, 32'hCAFE, 32'd0, "mtlo");
      start = 1'b1; flush = 1'b1; op = 3'd1; opa = 32'd9; opb = 32'd9;
      tick();
      start = 1'b0; flush = 1'b0; op = 3'd0;
      chk("stflush_busy", busy, 32'd0);
      tick();
      chk("stflush_hi", hi, expHi);
      chk("stflush_lo", lo, expLo);

      // Random ops against the model.
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: b = $urandom_range(1, 20);
            2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            default: b = $urandom;
         endcase
         doOp(o, a, b, "rnd");
      end

      repeat (3) tick();
      chk("pending_empty", expQ.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
